// File: rtl/id_ex_operand_stage_pkg.sv
// Shared ALU function encodings and register-index width for the ID/EX boundary.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package id_ex_operand_stage_pkg;

    localparam int REG_IDX_W = 5;
    localparam int ALU_OP_W  = 4;

    localparam logic [ALU_OP_W-1:0] FUNC_ZERO = 4'h0;
    localparam logic [ALU_OP_W-1:0] FUNC_ADD  = 4'h1;
    localparam logic [ALU_OP_W-1:0] FUNC_SUB  = 4'h2;
    localparam logic [ALU_OP_W-1:0] FUNC_AND  = 4'h3;
    localparam logic [ALU_OP_W-1:0] FUNC_OR   = 4'h4;
    localparam logic [ALU_OP_W-1:0] FUNC_XOR  = 4'h5;
    localparam logic [ALU_OP_W-1:0] FUNC_SLT  = 4'h6;
    localparam logic [ALU_OP_W-1:0] FUNC_SLL  = 4'h7;
    localparam logic [ALU_OP_W-1:0] FUNC_SRL  = 4'h8;
    localparam logic [ALU_OP_W-1:0] FUNC_SRA  = 4'h9;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand bypass: picks EX/MEM result, else MEM/WB result, else register-file data.
// Latency: combinational, zero cycles.
// Backpressure: none; re-evaluates every cycle on live forwarding inputs.
module fwd_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [XLEN-1:0]      rs_data,
    input  logic [REG_IDX_W-1:0] ex_mem_rd,
    input  logic                 ex_mem_reg_write,
    input  logic [XLEN-1:0]      ex_mem_result,
    input  logic [REG_IDX_W-1:0] mem_wb_rd,
    input  logic                 mem_wb_reg_write,
    input  logic [XLEN-1:0]      mem_wb_result,
    output logic [XLEN-1:0]      fwd_data
);

    logic rs_nonzero;
    logic hit_ex_mem;
    logic hit_mem_wb;

    // x0 is hardwired zero, so a producer targeting it must never bypass
    assign rs_nonzero = (rs != '0);
    assign hit_ex_mem = ex_mem_reg_write && (ex_mem_rd == rs) && rs_nonzero;
    assign hit_mem_wb = mem_wb_reg_write && (mem_wb_rd == rs) && rs_nonzero;

    // Younger producer (EX/MEM) wins over older one (MEM/WB)
    always_comb begin
        fwd_data = rs_data;
        if (hit_ex_mem) begin
            fwd_data = ex_mem_result;
        end else if (hit_mem_wb) begin
            fwd_data = mem_wb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU inputs.
// Latency: one cycle in->out; one instruction per cycle when out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready; a stalled entry holds all fields.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = ALU_OP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [OP_W-1:0]      in_alu_op,
    input  logic                 in_alu_src,
    input  logic                 in_reg_write,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] ex_mem_rd,
    input  logic                 ex_mem_reg_write,
    input  logic [XLEN-1:0]      ex_mem_result,
    input  logic [REG_IDX_W-1:0] mem_wb_rd,
    input  logic                 mem_wb_reg_write,
    input  logic [XLEN-1:0]      mem_wb_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      alu_op,
    output logic [XLEN-1:0]      alu_in_1,
    output logic [XLEN-1:0]      alu_in_2,
    output logic [XLEN-1:0]      store_data,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_reg_write
);

    logic                 valid_q;
    logic [REG_IDX_W-1:0] rs1_q;
    logic [REG_IDX_W-1:0] rs2_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic [XLEN-1:0]      rs1_data_q;
    logic [XLEN-1:0]      rs2_data_q;
    logic [XLEN-1:0]      imm_q;
    logic [OP_W-1:0]      alu_op_q;
    logic                 alu_src_q;
    logic                 reg_write_q;

    logic                 load;
    logic [XLEN-1:0]      fwd_rs1;
    logic [XLEN-1:0]      fwd_rs2;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Pipeline register: reset beats flush, flush beats load, otherwise drain or hold
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_op_q    <= OP_W'(FUNC_ZERO);
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q     <= 1'b1;
            rs1_q       <= in_rs1;
            rs2_q       <= in_rs2;
            rd_q        <= in_rd;
            rs1_data_q  <= in_rs1_data;
            rs2_data_q  <= in_rs2_data;
            imm_q       <= in_imm;
            alu_op_q    <= in_alu_op;
            alu_src_q   <= in_alu_src;
            reg_write_q <= in_reg_write;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Bypass on live producer state so a stalled instruction still picks up new results
    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs               (rs1_q),
        .rs_data          (rs1_data_q),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_result    (ex_mem_result),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_result    (mem_wb_result),
        .fwd_data         (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs               (rs2_q),
        .rs_data          (rs2_data_q),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_result    (ex_mem_result),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_result    (mem_wb_result),
        .fwd_data         (fwd_rs2)
    );

    assign out_valid     = valid_q;
    assign out_rd        = rd_q;
    assign alu_in_1      = fwd_rs1;
    assign alu_in_2      = alu_src_q ? imm_q : fwd_rs2;
    assign store_data    = fwd_rs2;
    // Bubbles must look harmless downstream: no write-back, neutral opcode
    assign out_reg_write = valid_q && reg_write_q;
    assign alu_op        = valid_q ? alu_op_q : OP_W'(FUNC_ZERO);

endmodule
